// File: rtl/if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : if_fetch_unit                                              |
// | Description : Instruction-fetch front end. Owns the PC, drives the       |
// |               synchronous instruction SRAM and fills the IF/ID register. |
// |               A skid register keeps SRAM read data alive across stalls.  |
// | Options     : FETCH_PERF_CNT_EN adds fetch/stall/flush event counters.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        if_id_stall,
  input  logic        im_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] im_addr,
  output logic        im_cs,
  input  logic [31:0] im_dout,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [31:0] C_PC_RESET = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_fetch_vld;
  logic [31:0] r_skid_inst;
  logic        r_skid_vld;
  logic        w_kill;
  logic        w_capture;
  logic        w_skid_clr;
  logic        w_load_valid;
  logic [31:0] w_avail_inst;
  logic [31:0] w_target;

  // A redirect or flush both kill whatever is about to enter IF/ID.
  assign w_kill       = branch_taken | im_flush;
  // All target bits take part; the low two are simply masked off.
  assign w_target     = branch_target & 32'hFFFF_FFFC;
  // While holding, the SRAM output already belongs to the next PC, so the
  // captured copy is the real data for fetch_pc.
  assign w_avail_inst = r_skid_vld ? r_skid_inst : im_dout;
  assign w_load_valid = ~w_kill & ~if_id_stall & r_fetch_vld;
  assign im_addr      = r_pc;
  assign im_cs        = (r_state != ST_BOOT);

  // State register: BOOT lasts one cycle after reset, then RUN/HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus the skid capture/clear strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_skid_clr  = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (if_id_stall && r_fetch_vld && !w_kill) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!if_id_stall || w_kill) begin
          w_state_nxt = ST_RUN;
          w_skid_clr  = 1'b1;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_kill) w_skid_clr = 1'b1;
  end

  // PC and fetch tracking: redirect beats stall, stall freezes both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= C_PC_RESET;
      r_fetch_pc  <= C_PC_RESET;
      r_fetch_vld <= 1'b0;
    end else if (r_state != ST_BOOT) begin
      if (branch_taken) begin
        r_pc        <= w_target;
        r_fetch_pc  <= r_pc;
        r_fetch_vld <= 1'b0;
      end else if (!pc_stall) begin
        r_pc        <= r_pc + 32'd4;
        r_fetch_pc  <= r_pc;
        r_fetch_vld <= 1'b1;
      end
    end
  end

  // Skid register: grab SRAM data when entering HOLD, drop it on exit/kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_inst <= NOP_INST;
      r_skid_vld  <= 1'b0;
    end else if (w_capture) begin
      r_skid_inst <= im_dout;
      r_skid_vld  <= 1'b1;
    end else if (w_skid_clr) begin
      r_skid_vld  <= 1'b0;
    end
  end

  // IF/ID register: kill, then hold, then load real instruction or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= 32'd0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (w_kill) begin
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (w_load_valid) begin
      if_id_pc    <= r_fetch_pc;
      if_id_inst  <= w_avail_inst;
      if_id_valid <= 1'b1;
    end else if (!if_id_stall) begin
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (w_load_valid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_id_stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (w_kill)       perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the 5-stage core. Owns the PC register, drives the synchronous instruction SRAM, and fills the IF/ID pipeline register. It is the consumer of the hazard controller's stall/flush outputs and of the EX-stage branch redirect. A skid register preserves SRAM read data across stalls, so no fetch is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, instruction inserted on flush (addi x0,x0,0)

- clk  input  1  core clock
- rst  input  1  reset; asynchronous, active-high
- pc_stall  input  1  hold PC (no increment)
- if_id_stall  input  1  hold IF/ID register contents
- im_flush  input  1  replace instruction entering IF/ID with NOP
- branch_taken  input  1  redirect request from EX (branch/JAL/JALR)
- branch_target  input  32  redirect address; bits [1:0] ignored (forced 0)
- im_addr  output  32  SRAM word address (byte address, {pc[31:2],2'b00})
- im_cs  output  1  SRAM chip select
- im_dout  input  32  SRAM read data, valid one cycle after address
- if_id_pc  output  32  PC of instruction in IF/ID
- if_id_inst  output  32  instruction in IF/ID
- if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction

## Operation
- Registers: pc_q, fetch_pc_q (PC whose data is on im_dout), fetch_vld_q, skid_inst_q/skid_vld_q, IF/ID registers, state.
- im_addr = pc_q; im_cs = 1 except in BOOT.
- States: BOOT -> RUN (unconditionally, one cycle after reset release); RUN -> HOLD when if_id_stall=1 and fetch_vld_q=1 and no flush/redirect; HOLD -> RUN when if_id_stall=0 or flush/redirect.
- Available instruction: skid_vld_q ? skid_inst_q : im_dout; available PC: fetch_pc_q.
- Next PC priority: branch_taken -> {branch_target[31:2],2'b00}; else pc_stall -> pc_q; else pc_q+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0).
- fetch_pc_q <= pc_q and fetch_vld_q <= ~branch_taken whenever the PC advances or redirects; both held when pc_stall=1 without redirect.
- IF/ID update priority: (branch_taken | im_flush) -> inst=NOP_INST, valid=0, pc unchanged; else if_id_stall -> hold; else if fetch_vld_q -> load available pc/inst, valid=1; else load bubble (NOP, valid=0).
- Skid: on RUN->HOLD capture im_dout into skid_inst_q, skid_vld_q=1; cleared on leaving HOLD, on flush, or on redirect.
- Simultaneous branch_taken and pc_stall: redirect wins; stalls ignored for that cycle.

## Timing
- Reset (async assert): pc_q=RESET_PC, fetch_vld_q=0, skid_vld_q=0, state=BOOT, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, im_cs=0.
- Fetch latency: address in cycle n, IF/ID valid at end of cycle n+1.
- First valid IF/ID: 3rd rising edge after reset deassertion (BOOT, address, capture).
- Redirect penalty: 2 bubbles (valid=0) before the target instruction appears in IF/ID.
- Reset asserted mid-stall/mid-redirect: all state returns to reset values immediately; skid contents discarded.
- Throughput: one instruction per cycle with no stall/flush.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (IF/ID loads with valid=1), perf_stall_cnt[31:0] (cycles with if_id_stall=1), perf_flush_cnt[31:0] (cycles with im_flush|branch_taken); all reset to 0, wrap at 2^32.
- Not defined: ports and counters absent; core behaviour identical.

## Test plan
- Reset release, no stalls -> im_addr 0,4,8,...; if_id_valid first 1 on 3rd edge with if_id_pc=0, then pc increments by 4 per cycle.
- Hold pc_stall=if_id_stall=1 for 3 cycles while IF/ID holds pc 8, then release -> IF/ID shows 8 during stall, then 12,16 with no skip/duplicate (skid supplies 12's data).
- branch_taken=1, target 32'h0000_0103 at pc 20 -> im_addr 32'h100 next cycle; 2 bubbles (inst=32'h13, valid=0); then if_id_pc=32'h100.
- im_flush=1 for one cycle alone -> IF/ID inst=32'h13, valid=0 that cycle; PC keeps advancing.
- branch_taken and pc_stall/if_id_stall together -> redirect occurs, skid cleared.
- RESET_PC=32'hFFFF_FFF8, run 3 cycles -> im_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; with FETCH_PERF_CNT_EN, perf_fetch_cnt matches valid loads.
